// File: rtl/clock_mode_controller.sv
// rtl/clock_mode_controller.sv - button-driven mode sequencer for the clock/stopwatch/timer datapath
// Every output is registered; button edges act one cycle after they are sampled.
module clock_mode_controller #(
  parameter bit BACKGROUND_RUN = 1'b1,
  parameter int REPEAT_DELAY   = 2,
  parameter int IDLE_TIMEOUT   = 10,
  parameter int ALARM_SECS     = 30
) (
  input  logic       clk_1Hz,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_set,
  input  logic       btn_sel,
  input  logic       btn_up,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       is_stopwatch_running,
  input  logic       is_timer_running,
  input  logic       timer_done,
  output logic       set_time_mode,
  output logic       set_timer_mode,
  output logic       stopwatch_mode,
  output logic       timer_mode,
  output logic       inc_hours,
  output logic       inc_minutes,
  output logic       inc_timer_hours,
  output logic       inc_timer_minutes,
  output logic       inc_timer_seconds,
  output logic       start_stopwatch,
  output logic       stop_stopwatch,
  output logic       reset_stopwatch,
  output logic       start_timer,
  output logic       stop_timer,
  output logic       reset_timer,
  output logic [1:0] display_sel,
  output logic [1:0] field_sel,
  output logic       blink,
  output logic       alarm_out
);
  localparam int HW = $clog2(REPEAT_DELAY + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam int AW = $clog2(ALARM_SECS + 1);

  localparam logic [10:0] P_INC_H    = 11'b100_0000_0000;
  localparam logic [10:0] P_INC_M    = 11'b010_0000_0000;
  localparam logic [10:0] P_INC_TH   = 11'b001_0000_0000;
  localparam logic [10:0] P_INC_TM   = 11'b000_1000_0000;
  localparam logic [10:0] P_INC_TS   = 11'b000_0100_0000;
  localparam logic [10:0] P_START_SW = 11'b000_0010_0000;
  localparam logic [10:0] P_STOP_SW  = 11'b000_0001_0000;
  localparam logic [10:0] P_RST_SW   = 11'b000_0000_1000;
  localparam logic [10:0] P_START_T  = 11'b000_0000_0100;
  localparam logic [10:0] P_STOP_T   = 11'b000_0000_0010;
  localparam logic [10:0] P_RST_T    = 11'b000_0000_0001;

  typedef enum logic [2:0] {S_CLOCK, S_CLK_SET, S_SW, S_TMR, S_TMR_SET} state_t;
  state_t state, state_n;

  logic [5:0]    btn, btn_prev, rise;
  logic          timer_done_prev, done_rise, any_rise, alarm_cancel;
  logic          in_set, next_in_set, inc_req, alarm_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [IW-1:0] idle_cnt, idle_n;
  logic [AW-1:0] alarm_cnt, alarm_cnt_n;
  logic [1:0]    field_n, disp_n;
  logic [10:0]   pulse_n, pulse_q;

  assign btn         = {btn_clear, btn_start, btn_up, btn_sel, btn_set, btn_mode};
  assign rise        = btn & ~btn_prev;
  assign any_rise    = |rise;
  assign done_rise   = timer_done & ~timer_done_prev;
  assign in_set      = (state == S_CLK_SET) || (state == S_TMR_SET);
  assign next_in_set = (state_n == S_CLK_SET) || (state_n == S_TMR_SET);

  assign {inc_hours, inc_minutes, inc_timer_hours, inc_timer_minutes, inc_timer_seconds,
          start_stopwatch, stop_stopwatch, reset_stopwatch,
          start_timer, stop_timer, reset_timer} = pulse_q;

  always_comb begin
    state_n      = state;
    field_n      = field_sel;
    pulse_n      = '0;
    inc_req      = 1'b0;
    alarm_cancel = 1'b0;
    // One action per cycle; an edge that has no meaning in this state still masks lower ones.
    if (alarm_out && any_rise) begin
      alarm_cancel = 1'b1;
    end else if (rise[1]) begin
      case (state)
        S_CLOCK:   begin state_n = S_CLK_SET; field_n = 2'd0; end
        S_CLK_SET: state_n = S_CLOCK;
        S_TMR:     if (!is_timer_running) begin state_n = S_TMR_SET; field_n = 2'd0; end
        S_TMR_SET: state_n = S_TMR;
        default:   ;
      endcase
    end else if (rise[0]) begin
      case (state)
        S_CLOCK: state_n = S_SW;
        S_SW:    state_n = S_TMR;
        S_TMR:   state_n = S_CLOCK;
        default: ;
      endcase
    end else if (rise[2]) begin
      if (state == S_CLK_SET)      field_n = (field_sel == 2'd0) ? 2'd1 : 2'd0;
      else if (state == S_TMR_SET) field_n = (field_sel == 2'd2) ? 2'd0 : field_sel + 2'd1;
    end else if (rise[3]) begin
      inc_req = in_set;
    end else if (rise[4]) begin
      if (state == S_SW)       pulse_n = is_stopwatch_running ? P_STOP_SW : P_START_SW;
      else if (state == S_TMR) pulse_n = is_timer_running ? P_STOP_T : P_START_T;
    end else if (rise[5]) begin
      if (state == S_SW)       pulse_n = P_RST_SW;
      else if (state == S_TMR) pulse_n = P_RST_T;
    end else if (in_set && btn_up && hold_cnt >= HW'(REPEAT_DELAY)) begin
      inc_req = 1'b1;
    end

    if (in_set && !any_rise && idle_cnt == IW'(IDLE_TIMEOUT - 1)) begin
      state_n = (state == S_CLK_SET) ? S_CLOCK : S_TMR;
      inc_req = 1'b0;
    end

    if (inc_req) begin
      if (state == S_CLK_SET) pulse_n = (field_sel == 2'd0) ? P_INC_H : P_INC_M;
      else begin
        case (field_sel)
          2'd0:    pulse_n = P_INC_TH;
          2'd1:    pulse_n = P_INC_TM;
          default: pulse_n = P_INC_TS;
        endcase
      end
    end

    if (state_n != state || !next_in_set || any_rise) idle_n = '0;
    else idle_n = (idle_cnt == IW'(IDLE_TIMEOUT)) ? idle_cnt : idle_cnt + 1'b1;

    if (!btn_up || state_n != state) hold_n = '0;
    else hold_n = (hold_cnt == HW'(REPEAT_DELAY)) ? hold_cnt : hold_cnt + 1'b1;

    alarm_cnt_n = alarm_cnt;
    alarm_n     = alarm_out;
    if (done_rise) begin
      alarm_cnt_n = AW'(ALARM_SECS);
      alarm_n     = 1'b1;
    end else if (alarm_cancel) begin
      alarm_cnt_n = '0;
      alarm_n     = 1'b0;
    end else if (alarm_out && alarm_cnt != '0) begin
      alarm_cnt_n = alarm_cnt - 1'b1;
      alarm_n     = (alarm_cnt != AW'(1));
    end

    case (state_n)
      S_SW:             disp_n = 2'd1;
      S_TMR, S_TMR_SET: disp_n = 2'd2;
      default:          disp_n = 2'd0;
    endcase
  end

  always_ff @(posedge clk_1Hz) begin
    if (reset) state <= S_CLOCK;
    else       state <= state_n;
  end

  always_ff @(posedge clk_1Hz) begin
    if (reset) begin
      btn_prev        <= btn;
      timer_done_prev <= timer_done;
      hold_cnt        <= '0;
      idle_cnt        <= '0;
      alarm_cnt       <= '0;
      pulse_q         <= '0;
      set_time_mode   <= 1'b0;
      set_timer_mode  <= 1'b0;
      stopwatch_mode  <= BACKGROUND_RUN;
      timer_mode      <= BACKGROUND_RUN;
      display_sel     <= 2'd0;
      field_sel       <= 2'd0;
      blink           <= 1'b0;
      alarm_out       <= 1'b0;
    end else begin
      btn_prev        <= btn;
      timer_done_prev <= timer_done;
      hold_cnt        <= hold_n;
      idle_cnt        <= idle_n;
      alarm_cnt       <= alarm_cnt_n;
      pulse_q         <= pulse_n;
      set_time_mode   <= (state_n == S_CLK_SET);
      set_timer_mode  <= (state_n == S_TMR_SET);
      stopwatch_mode  <= BACKGROUND_RUN || (state_n == S_SW);
      timer_mode      <= BACKGROUND_RUN || (state_n == S_TMR) || (state_n == S_TMR_SET);
      display_sel     <= disp_n;
      field_sel       <= field_n;
      blink           <= next_in_set ? ~blink : 1'b0;
      alarm_out       <= alarm_n;
    end
  end
endmodule

// File: doc/clock_mode_controller.md
# clock_mode_controller

User-interface sequencer for the clock/stopwatch/timer datapath. It takes six debounced push-button levels and the datapath status flags, runs a mode state machine, and drives every control input of the clock datapath as registered levels or single-cycle pulses. It also generates display-select, field-blink and alarm outputs. It sits between the board button conditioning and the clock datapath, in the same `clk_1Hz` domain.

## Interface
- `BACKGROUND_RUN`, 1: 1 holds `stopwatch_mode` and `timer_mode` high in every state; 0 holds each high only in its own state(s).
- `REPEAT_DELAY`, 2: cycles `btn_up` must stay high before auto-repeat starts (≥1).
- `IDLE_TIMEOUT`, 10: cycles without any button rising edge before a set state auto-exits (≥2).
- `ALARM_SECS`, 30: alarm duration in cycles (≥1).
- `clk_1Hz` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `btn_mode`, `btn_set`, `btn_sel`, `btn_up`, `btn_start`, `btn_clear` in 1 each: debounced, synchronized button levels.
- `is_stopwatch_running`, `is_timer_running`, `timer_done` in 1 each: datapath status.
- `set_time_mode`, `set_timer_mode`, `stopwatch_mode`, `timer_mode` out 1 each: datapath mode levels.
- `inc_hours`, `inc_minutes`, `inc_timer_hours`, `inc_timer_minutes`, `inc_timer_seconds` out 1 each: one-cycle increment pulses.
- `start_stopwatch`, `stop_stopwatch`, `reset_stopwatch`, `start_timer`, `stop_timer`, `reset_timer` out 1 each: one-cycle command pulses.
- `display_sel` out 2: 0 = clock, 1 = stopwatch, 2 = timer.
- `field_sel` out 2: field being edited; 0 = hours, 1 = minutes, 2 = seconds.
- `blink` out 1: edit-field blink.
- `alarm_out` out 1: alarm drive.

## Operation
- **Edge detection.** For each button, `prev` is a register. A rising edge is `btn & ~prev`. During reset, `prev` loads the current button levels, so a button held through reset does not produce an edge.
- **One action per cycle.** Priority, highest first: alarm cancel, `set`, `mode`, `sel`, `up`, `start`, `clear`. Lower-priority edges in the same cycle are dropped.
- **States and transitions.** States are CLOCK, CLK_SET, SW, TMR, TMR_SET. Reset state is CLOCK.
  - CLOCK: `mode` → SW. `set` → CLK_SET with `field_sel` = 0.
  - SW: `mode` → TMR. `start` pulses `stop_stopwatch` if `is_stopwatch_running`, else `start_stopwatch`. `clear` pulses `reset_stopwatch`.
  - TMR: `mode` → CLOCK. `start` pulses `stop_timer` if `is_timer_running`, else `start_timer`. `clear` pulses `reset_timer`. `set` → TMR_SET with `field_sel` = 0, only when `is_timer_running` = 0; otherwise it is ignored.
  - CLK_SET: `sel` toggles `field_sel` between 0 and 1. `up` pulses `inc_hours` (field 0) or `inc_minutes` (field 1). `set` → CLOCK. `mode` is ignored.
  - TMR_SET: `sel` cycles `field_sel` 0→1→2→0. `up` pulses `inc_timer_hours`, `inc_timer_minutes` or `inc_timer_seconds` for field 0, 1, 2. `set` → TMR. `mode` is ignored.
- **Auto-repeat (set states only).** A hold counter counts consecutive cycles with `btn_up` high. Once it reaches `REPEAT_DELAY`, the current field's increment pulses every cycle while `btn_up` stays high. The counter clears when `btn_up` is low and on any state change.
- **Idle timeout (set states only).** An idle counter resets on any button rising edge and on set-state entry. When it reaches `IDLE_TIMEOUT`, the FSM returns to the parent state (CLOCK or TMR).
- **Mode levels.**
  - `set_time_mode` = 1 iff state is CLK_SET.
  - `set_timer_mode` = 1 iff state is TMR_SET.
  - `stopwatch_mode` / `timer_mode` follow `BACKGROUND_RUN`: with 0, `stopwatch_mode` is high in SW and `timer_mode` in TMR or TMR_SET.
- **Display outputs.** `display_sel` is 0 for CLOCK/CLK_SET, 1 for SW, 2 for TMR/TMR_SET. `field_sel` holds its last value outside set states. `blink` toggles every cycle in set states and is 0 elsewhere.
- **Alarm.** A rising edge of `timer_done` loads the alarm counter with `ALARM_SECS` and sets `alarm_out`. `alarm_out` clears when the counter expires. Any button rising edge while `alarm_out` = 1 clears the alarm and is consumed, with no other action. A new `timer_done` edge during an alarm reloads the counter. The alarm works in every state.

## Timing
- All outputs are registered.
- A button rising edge sampled at edge N produces its pulse or state change from edge N to edge N+1. The datapath therefore acts on it at edge N+1.
- Pulses are exactly one cycle wide. Two pulses never overlap, except auto-repeat, which gives a continuous high.
- Reset values: all outputs 0 and `display_sel`/`field_sel` = 0. Exceptions: `stopwatch_mode` and `timer_mode` = 1 on the first cycle after reset when `BACKGROUND_RUN` = 1. All counters are 0.
- Reset mid-operation (in a set state, during repeat or during an alarm) aborts it immediately: state CLOCK, no pending pulses.
- Counter widths are sized to their parameters (clog2). Counters saturate and do not wrap.

## Test plan
- Reset, then three `btn_mode` presses → `display_sel` goes 1, 2, 0. No command pulses occur.
- In CLOCK, press `set`, then `up`, then `sel`, then `up` → one `inc_hours` pulse, then one `inc_minutes` pulse, each exactly one cycle, one cycle after its press.
- In TMR_SET with `REPEAT_DELAY` = 2, hold `btn_up` 5 cycles on field 2 → `inc_timer_seconds` high on cycles 1, 3, 4, 5 after the press.
- In SW, press `start` with `is_stopwatch_running` = 0 → `start_stopwatch` pulse. Press `start` again with it at 1 → `stop_stopwatch` pulse. Press `clear` → `reset_stopwatch` pulse.
- Assert a `timer_done` rise → `alarm_out` stays high 30 cycles. Repeat, then press `mode` at cycle 5 → `alarm_out` low next cycle and `display_sel` unchanged.
- Enter CLK_SET and leave the buttons idle 10 cycles → state returns to CLOCK, `set_time_mode` = 0, `blink` = 0.
